// File: rtl/nf_uart_rx_fifo.sv
// UART 8N1 receiver (majority-voted mid-bit sampling) feeding a show-ahead FIFO; byte visible 1 cycle after stop decision.
// Pop is valid/ready; a push into a full FIFO without a same-cycle pop drops the byte and sets the sticky overrun flag.
module nf_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CW-1:0]            comp,
    input  logic                     rec_en,
    input  logic                     uart_rx,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     frame_err,
    output logic                     overrun,
    input  logic                     err_clr
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_WAITHI = 3'd4;

    logic          sync1_q, sync2_q;
    logic [2:0]    hist_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          push, ferr_set;
    logic          maj, fall, comp_ok;
    logic [CW-1:0] half, last;

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wp_q, rp_q;
    logic          empty, full, pop, wr_en, ovr_set;
    logic          frame_err_q, overrun_q;

    assign maj     = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    assign fall    = ~sync2_q & hist_q[0];
    assign comp_ok = comp >= CW'(4);
    assign half    = comp >> 1;
    assign last    = comp - CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 3'b111;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            hist_q  <= {hist_q[1:0], sync2_q};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rec_en && comp_ok && fall) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == half) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = maj ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == last) begin
                    sh_d  = {maj, sh_q[7:1]};
                    cnt_d = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == last) begin
                    cnt_d = '0;
                    if (maj) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_WAITHI;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAITHI: begin
                // Hold off until the line is released so a break is not seen as new frames.
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!rec_en && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            push     = 1'b0;
            ferr_set = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sh_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign pop     = ~empty & rx_ready;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign wr_en   = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            if (wr_en) begin
                mem_q[wp_q[AW-1:0]] <= sh_q;
                wp_q                <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            frame_err_q <= ferr_set | (frame_err_q & ~err_clr);
            overrun_q   <= ovr_set  | (overrun_q   & ~err_clr);
        end
    end

    assign rx_data   = mem_q[rp_q[AW-1:0]];
    assign rx_valid  = ~empty;
    assign count     = wp_q - rp_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule
